// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state encoding and default sizes for the multi-port register file
package reg_file_pkg;
  typedef enum logic {RF_CLEAR = 1'b0, RF_RUN = 1'b1} rf_state_t;
  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one read path with zero-register masking, not-ready masking and optional bypass (REG_FILE_MP_BYPASS_EN)
module rf_read_port import reg_file_pkg::*; #(
  parameter int XLEN     = RF_XLEN,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic            i_run,
`ifdef REG_FILE_MP_BYPASS_EN
  input  logic            i_wen0,
  input  logic [AW-1:0]   i_wa0,
  input  logic [XLEN-1:0] i_wd0,
  input  logic            i_wen1,
  input  logic [AW-1:0]   i_wa1,
  input  logic [XLEN-1:0] i_wd1,
`endif
  output logic [XLEN-1:0] o_data
);
  logic            w_zero;
  logic [XLEN-1:0] w_fwd;
  assign w_zero = (ZERO_REG != 0) && (i_addr == '0);
`ifdef REG_FILE_MP_BYPASS_EN
  // the write enables arrive already qualified, so a dropped port-0 write never forwards
  assign w_fwd = (i_wen1 && i_wa1 == i_addr) ? i_wd1 :
                 (i_wen0 && i_wa0 == i_addr) ? i_wd0 : i_data;
`else
  assign w_fwd = i_data;
`endif
  assign o_data = (i_run && !w_zero) ? w_fwd : '0;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two prioritised write ports and a post-reset clear sweep; REG_FILE_MP_BYPASS_EN adds write-to-read forwarding
module reg_file_mp import reg_file_pkg::*; #(
  parameter int XLEN     = RF_XLEN,
  parameter int NREG     = RF_NREG,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  output logic                ready,
  output logic                wr_drop
);
  rf_state_t       r_state;
  logic [AW-1:0]   r_clr_idx;
  logic [XLEN-1:0] r_mem [NREG];
  logic            r_ready;
  logic            r_wr_drop;
  logic            w_run;
  logic            w_z0;
  logic            w_z1;
  logic            w_hit;
  logic            w_wen0;
  logic            w_wen1;
  logic            w_drop;
  assign w_run  = (r_state == RF_RUN) && !rst;
  assign w_z0   = (ZERO_REG != 0) && (wa0 == '0);
  assign w_z1   = (ZERO_REG != 0) && (wa1 == '0);
  assign w_hit  = we0 && we1 && (wa0 == wa1);
  assign w_wen1 = w_run && we1 && !w_z1;
  assign w_wen0 = w_run && we0 && !w_z0 && !w_hit;
  // a collision on the zero register is silently ignored; any write outside RUN is dropped
  assign w_drop = w_run ? (w_hit && !w_z1) : (we0 || we1);
  // clear sweep sequencer with registered ready and drop flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_drop;
      if (r_state == RF_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
        if (r_clr_idx == AW'(NREG - 1)) begin
          r_state <= RF_RUN;
          r_ready <= 1'b1;
        end
      end
    end
  end
  // storage: the sweep zeroes one entry per cycle, otherwise port 1 is written after port 0 so it wins
  always_ff @(posedge clk) begin
    if (!rst && r_state == RF_CLEAR) r_mem[r_clr_idx] <= '0;
    else begin
      if (w_wen0) r_mem[wa0] <= wd0;
      if (w_wen1) r_mem[wa1] <= wd1;
    end
  end
  assign ready   = r_ready;
  assign wr_drop = r_wr_drop;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd (
      .i_addr (rd_addr[i*AW +: AW]),
      .i_data (r_mem[rd_addr[i*AW +: AW]]),
      .i_run  (w_run),
`ifdef REG_FILE_MP_BYPASS_EN
      .i_wen0 (w_wen0),
      .i_wa0  (wa0),
      .i_wd0  (wd0),
      .i_wen1 (w_wen1),
      .i_wa1  (wa1),
      .i_wd1  (wd1),
`endif
      .o_data (rd_data[i*XLEN +: XLEN])
    );
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, the next generation of the core's single-write, dual-read register file. Sits in the decode/writeback stage of the single-cycle datapath. Adds these capabilities:
- configurable width, depth and read-port count;
- two prioritised write ports;
- optional hardwired zero register;
- a hardware clear sequencer that zeroes every entry after reset and handshakes readiness to the control unit.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 4.
- AW, $clog2(NREG), address width; derived, not to be overridden.
- NRD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- ready  out  1  high once clearing is complete and the file is usable.
- wr_drop  out  1  one-cycle pulse when an enabled write was discarded.

Behaviour:
- State machine has two states, CLEAR and RUN, with a counter clr_idx of AW bits.
- rst high at a clock edge:
  - next state is CLEAR and clr_idx becomes 0;
  - ready becomes 0 and wr_drop becomes 0;
  - memory contents are not otherwise touched that cycle.
- CLEAR with rst low, each edge:
  - mem[clr_idx] is written to 0 and clr_idx increments;
  - when clr_idx == NREG-1, that entry is written and the next state is RUN.
- Clear latency: ready rises NREG edges after the first edge with rst low (32 cycles at default).
- Reset during CLEAR restarts the sweep from index 0.
- Reset in RUN re-enters CLEAR and re-clears all entries.
- Outputs during CLEAR or reset:
  - ready = 0;
  - all rd_data = 0;
  - any we0/we1 is discarded, and wr_drop pulses high the next cycle (registered).
- Reads in RUN:
  - Read paths are combinational and asynchronous: rd_data[i] = mem[rd_addr[i]].
  - With ZERO_REG = 1, address 0 always returns 0.
- Writes in RUN:
  - Commit on the rising edge.
  - With ZERO_REG = 1, a write to address 0 is silently ignored and does not raise wr_drop.
  - Both ports enabled with wa0 == wa1: port 1 wins, wd0 is discarded, and wr_drop pulses the next cycle.
  - Both ports enabled with different addresses: both commit in the same edge.
- ready and wr_drop are registered outputs.
- No read-during-write hazard without bypass: a same-cycle read returns the old value.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined:
  - In RUN, a read port whose address matches an enabled, non-dropped write in the same cycle returns the write data combinationally.
  - Port 1 takes priority over port 0.
  - Address 0 still reads 0 when ZERO_REG = 1.
- Undefined:
  - Reads return the pre-edge stored value; no forwarding muxes are generated.

Decomposition:
- Shared package reg_file_pkg holds:
  - state encoding typedef rf_state_t (RF_CLEAR = 1'b0, RF_RUN = 1'b1);
  - default constants RF_XLEN = 32 and RF_NREG = 32.
- One natural sub-module, rf_read_port:
  - one read path, instantiated NRD times in a generate loop;
  - contains the zero-register masking, the not-ready masking and the optional bypass mux.

Test Plan:
1. Hold rst high for 3 cycles, then release. Required: ready = 0 for exactly 32 edges then rises; rd_data = 0 throughout; after ready, every address reads 0x00000000.
2. In RUN, write we0 wa0 = 5 wd0 = 0x00000005 and we1 wa1 = 6 wd1 = 0x00000004 in the same cycle, then read addresses 5 and 6. Required: 0x5 and 0x4, no wr_drop.
3. Write both ports to address 9, with wd0 = 0xAAAA0000 and wd1 = 0x0000BBBB. Required: address 9 reads 0x0000BBBB; wr_drop is high for one cycle.
4. Write 0xDEADBEEF to address 0 with ZERO_REG = 1. Required: reads 0; no wr_drop. Repeat with ZERO_REG = 0: reads 0xDEADBEEF.
5. Assert rst at clear index 10, hold 1 cycle, and attempt we0 during CLEAR. Required: sweep restarts, ready rises 32 edges after release, wr_drop pulses, the write is not stored.
6. With REG_FILE_MP_BYPASS_EN defined, write 0x12345678 to address 3 while reading address 3. Required: same-cycle rd_data = 0x12345678. Without the macro: the old value (0) is returned.
